// File: rtl/bcd_event_counter_disp.sv
`default_nettype none
// ============================================================================
// Module   : bcd_event_counter_disp
// Brief    : Resynchronises debounced switch levels, counts rising edges of
//            the increment switch in an NDIG-digit BCD counter (clear switch
//            zeroes it), and scans the count onto a multiplexed 7-segment
//            display with optional leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_event_counter_disp #(
    parameter int NDIG   = 4,
    parameter int SCAN_W = 16,
    parameter int BLANK  = 1
) (
    input  logic              clk,
    input  logic              rst,     // asynchronous, active-low
    input  logic              sw_inc,
    input  logic              sw_clr,
    output logic [4*NDIG-1:0] bcd,
    output logic              ovf,
    output logic [6:0]        seg,
    output logic [NDIG-1:0]   an
);

    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NDIG - 1);

    // bit 0 = increment switch, bit 1 = clear switch
    logic [1:0]        r_s1_q, r_s2_q, r_s3_q;
    logic [1:0]        w_pulse;

    logic [4*NDIG-1:0] r_bcd_q, w_bcd_d;
    logic              r_ovf_q, w_ovf_d;
    logic              w_carry;

    logic [SCAN_W-1:0] r_presc_q, w_presc_d;
    logic [IDX_W-1:0]  r_idx_q, w_idx_d;

    logic [3:0]        w_digit;
    logic              w_upper_zero;
    logic [6:0]        w_seg_dec;

    // Three-flop chain: s1/s2 resynchronise, s3 holds the previous s2 for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_q <= 2'b00;
            r_s2_q <= 2'b00;
            r_s3_q <= 2'b00;
        end else begin
            r_s1_q <= {sw_clr, sw_inc};
            r_s2_q <= r_s1_q;
            r_s3_q <= r_s2_q;
        end
    end

    assign w_pulse = r_s2_q & ~r_s3_q;

    // BCD ripple increment within one clock; clear takes priority and suppresses overflow
    always_comb begin
        w_bcd_d = r_bcd_q;
        w_ovf_d = 1'b0;
        w_carry = w_pulse[0];
        if (w_pulse[1]) begin
            w_bcd_d = '0;
        end else begin
            for (int i = 0; i < NDIG; i++) begin
                if (w_carry) begin
                    if (r_bcd_q[4*i +: 4] == 4'd9) begin
                        w_bcd_d[4*i +: 4] = 4'd0;
                    end else begin
                        w_bcd_d[4*i +: 4] = r_bcd_q[4*i +: 4] + 4'd1;
                        w_carry           = 1'b0;
                    end
                end
            end
            // carry surviving every digit means all digits were 9
            w_ovf_d = w_carry;
        end
    end

    // Free-running prescaler; the scan index steps when it is all-ones
    always_comb begin
        w_presc_d = r_presc_q + SCAN_W'(1);
        w_idx_d   = r_idx_q;
        if (&r_presc_q) begin
            w_idx_d = (r_idx_q == c_idx_last) ? '0 : r_idx_q + IDX_W'(1);
        end
    end

    // Counter, overflow pulse and scan state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bcd_q   <= '0;
            r_ovf_q   <= 1'b0;
            r_presc_q <= '0;
            r_idx_q   <= '0;
        end else begin
            r_bcd_q   <= w_bcd_d;
            r_ovf_q   <= w_ovf_d;
            r_presc_q <= w_presc_d;
            r_idx_q   <= w_idx_d;
        end
    end

    // Digit select and blanking test: selected digit and everything above it are zero
    always_comb begin
        w_digit      = 4'd0;
        w_upper_zero = 1'b1;
        an           = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (r_idx_q == IDX_W'(i)) begin
                w_digit = r_bcd_q[4*i +: 4];
                an[i]   = 1'b1;
            end
            if ((IDX_W'(i) >= r_idx_q) && (r_bcd_q[4*i +: 4] != 4'd0)) begin
                w_upper_zero = 1'b0;
            end
        end
    end

    // Seven-segment decode (a = bit 0 ... g = bit 6)
    always_comb begin
        w_seg_dec = 7'h00;
        case (w_digit)
            4'd0:    w_seg_dec = 7'h3F;
            4'd1:    w_seg_dec = 7'h06;
            4'd2:    w_seg_dec = 7'h5B;
            4'd3:    w_seg_dec = 7'h4F;
            4'd4:    w_seg_dec = 7'h66;
            4'd5:    w_seg_dec = 7'h6D;
            4'd6:    w_seg_dec = 7'h7D;
            4'd7:    w_seg_dec = 7'h07;
            4'd8:    w_seg_dec = 7'h7F;
            4'd9:    w_seg_dec = 7'h6F;
            default: w_seg_dec = 7'h00;
        endcase
    end

    // Digit 0 is never blanked, so a zero count still shows a single 0
    always_comb begin
        seg = w_seg_dec;
        if ((BLANK != 0) && (r_idx_q != '0) && w_upper_zero) begin
            seg = 7'h00;
        end
    end

    assign bcd = r_bcd_q;
    assign ovf = r_ovf_q;

endmodule
`default_nettype wire
